whack_referee: RTL
==================

// Module: whack_referee
// PURPOSE
//  Game-side referee for Whack. Pops a mole into a pseudo-random hole and times the whack window.
//  Judges the player's key presses and reports each round result as a one-cycle pulse.
//  Keeps score and miss count, and raises game_over, which the control FSM consumes.
//  Rounds are driven by the control FSM's round_start/new_game pulses.
// PARAMETERS
//  NUM_HOLES      8         number of holes/keys, 2..16
//  HOLE_W         4         width of mole_pos, >= clog2(NUM_HOLES)
//  WINDOW_CYCLES  50000000  cycles mole stays up before a miss (1 s at 50 MHz)
//  MAX_MISSES     3         misses that end the game, 1..7
//  SCORE_W        8         score width; score saturates at all-ones
// PORTS
//  clk         in   1          system clock
//  Resetn      in   1          asynchronous active-low reset
//  new_game    in   1          pulse: clear score/misses, leave game-over state
//  round_start in   1          pulse: raise a mole and start the window
//  key_press   in   NUM_HOLES  player keys, level, already synchronised, active-high
//  mole_up     out  1          mole visible / window open
//  mole_pos    out  HOLE_W     hole index of current mole
//  whack       out  1          one-cycle pulse: correct hit this round
//  miss        out  1          one-cycle pulse: wrong key or timeout
//  score       out  SCORE_W    total whacks this game
//  misses      out  3          total misses this game
//  game_over   out  1          level: misses reached MAX_MISSES
// BEHAVIOUR
//  Reset: state S_IDLE.
//   - All outputs 0; mole_pos 0.
//   - LFSR = 16'hACE1; key_q = 0.
//  Press edge: press = key_press & ~key_q. key_q is registered every cycle in every state.
//  LFSR: 16-bit Fibonacci, taps 16,14,13,11.
//   - Steps every cycle; never zero.
//   - Round position = lfsr[7:0] % NUM_HOLES.
//  FSM: S_IDLE -> S_UP -> S_IDLE | S_OVER.
//   - S_IDLE, round_start=1: latch mole_pos; timer <= WINDOW_CYCLES-1; mole_up <= 1; go to S_UP.
//   - S_UP, press != 0:
//       - If press == (1<<mole_pos): whack <= 1; score += 1, saturating.
//       - Otherwise (including a correct key plus another key): miss <= 1; misses += 1.
//       - In both cases mole_up <= 0.
//   - S_UP, press == 0 and timer == 0: miss <= 1; misses += 1; mole_up <= 0.
//   - S_UP, otherwise: timer -= 1.
//   - After a result: go to S_OVER if the updated misses == MAX_MISSES, else S_IDLE.
//   - S_OVER: game_over = 1; round_start and keys ignored.
//  Timing:
//   - Window = exactly WINDOW_CYCLES cycles with mole_up=1.
//   - whack/miss rise in the cycle after the press edge or after the final window cycle.
//   - Exactly one whack or miss pulse per round; never both.
//  Boundaries:
//   - A press in the final window cycle counts as a press, not a timeout.
//   - A key held from before round_start is not an edge and produces no result.
//   - round_start in S_UP or S_OVER is ignored.
//   - Key presses in S_IDLE are ignored.
//   - new_game has priority in any state:
//       - Clears score, misses, game_over, mole_up, whack and miss; goes to S_IDLE.
//       - A same-cycle round_start is dropped.
//   - Resetn low mid-round aborts the round immediately (asynchronous); no pulse is emitted.
// STRUCTURE
//  whack_pkg (include): S_IDLE/S_UP/S_OVER encodings, LFSR_SEED 16'hACE1, LFSR tap mask.
//  Sub-module whack_lfsr16:
//   - Ports: clk, Resetn, out[15:0].
//   - Free-running; reused by the display/sound blocks.
//  Parent holds the FSM, window timer, score/miss counters and press-edge register.
// TESTING (WINDOW_CYCLES=10, NUM_HOLES=8, MAX_MISSES=3)
//  1. Correct hit:
//     - Stimulus: reset; round_start; press key[mole_pos] 4 cycles later.
//     - Expect: one whack pulse, score=1, mole_up drops, miss never asserted.
//  2. Timeout:
//     - Stimulus: round_start with no keys.
//     - Expect: mole_up high 10 cycles, then one miss pulse, misses=1.
//  3. Wrong key / double key:
//     - Stimulus: press key[(mole_pos+1)%8] -> miss.
//     - Next round: press correct key plus another key together -> miss. Expect misses=2.
//  4. Game over:
//     - Stimulus: 3 timeouts.
//     - Expect: game_over=1 after the 3rd miss.
//     - Then: round_start -> no mole. new_game -> score=0, misses=0, game_over=0.
//  5. Edges:
//     - Key held across round_start -> no result until released and re-pressed.
//     - Press in the 10th window cycle -> whack, not miss.
//     - new_game + round_start same cycle -> stays S_IDLE.
//  6. Reset mid-round:
//     - Stimulus: drop Resetn during S_UP.
//     - Expect: all outputs 0 immediately; LFSR=16'hACE1; score saturates at 255 in a forced-count run.

Source files
------------

// File: rtl/whack_pkg.sv
// Shared encodings for the Whack referee: FSM states and the mole-position LFSR.
package whack_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_UP   = 2'd1;
  localparam logic [1:0] S_OVER = 2'd2;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // x^16+x^14+x^13+x^11 in right-shift Fibonacci form taps bits 0,2,3,5
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return {^(cur & LFSR_TAPS), cur[15:1]};
  endfunction

endpackage

// File: rtl/whack_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR; also used by the display and sound blocks.
module whack_lfsr16
  import whack_pkg::*;
(
  input  logic        clk,
  input  logic        Resetn,
  output logic [15:0] out
);

  always_ff @(posedge clk or negedge Resetn) begin
    if (!Resetn) out <= LFSR_SEED;
    else         out <= lfsr_next(out);
  end

endmodule

// File: rtl/whack_referee.sv
// Whack referee: raises a mole in a pseudo-random hole, times the window,
// judges key-press edges and keeps score/miss counts.
//  state  | meaning
//  S_IDLE | no mole; waiting for round_start
//  S_UP   | mole visible, window timer running
//  S_OVER | miss limit reached; only new_game leaves
module whack_referee
  import whack_pkg::*;
#(
  parameter int NUM_HOLES     = 8,
  parameter int HOLE_W        = 4,
  parameter int WINDOW_CYCLES = 50000000,
  parameter int MAX_MISSES    = 3,
  parameter int SCORE_W       = 8
) (
  input  logic                 clk,
  input  logic                 Resetn,
  input  logic                 new_game,
  input  logic                 round_start,
  input  logic [NUM_HOLES-1:0] key_press,
  output logic                 mole_up,
  output logic [HOLE_W-1:0]    mole_pos,
  output logic                 whack,
  output logic                 miss,
  output logic [SCORE_W-1:0]   score,
  output logic [2:0]           misses,
  output logic                 game_over
);

  localparam int TIMER_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;

  logic [1:0]           state;
  logic [TIMER_W-1:0]   timer;
  logic [NUM_HOLES-1:0] key_q;
  logic [NUM_HOLES-1:0] press;
  logic [NUM_HOLES-1:0] target;
  logic [15:0]          lfsr_q;
  logic [7:0]           pos_raw;
  logic [2:0]           misses_inc;
  logic                 end_on_miss;
  logic                 unused_lfsr_hi;

  whack_lfsr16 u_lfsr (
    .clk    (clk),
    .Resetn (Resetn),
    .out    (lfsr_q)
  );

  assign unused_lfsr_hi = ^lfsr_q[15:8];
  assign pos_raw        = lfsr_q[7:0] % 8'(NUM_HOLES);
  assign press          = key_press & ~key_q;
  assign target         = NUM_HOLES'(1) << mole_pos;
  assign misses_inc     = misses + 3'd1;
  assign end_on_miss    = (misses_inc == 3'(MAX_MISSES));
  assign game_over      = (state == S_OVER);

  always_ff @(posedge clk or negedge Resetn) begin
    if (!Resetn) begin
      state    <= S_IDLE;
      timer    <= '0;
      key_q    <= '0;
      mole_up  <= 1'b0;
      mole_pos <= '0;
      whack    <= 1'b0;
      miss     <= 1'b0;
      score    <= '0;
      misses   <= '0;
    end else begin
      key_q <= key_press;
      whack <= 1'b0;
      miss  <= 1'b0;
      if (new_game) begin
        state   <= S_IDLE;
        mole_up <= 1'b0;
        score   <= '0;
        misses  <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (round_start) begin
              mole_pos <= HOLE_W'(pos_raw);
              timer    <= TIMER_W'(WINDOW_CYCLES - 1);
              mole_up  <= 1'b1;
              state    <= S_UP;
            end
          end
          S_UP: begin
            // a press edge beats the timeout, even in the last window cycle
            if (press != '0) begin
              mole_up <= 1'b0;
              if (press == target) begin
                whack <= 1'b1;
                if (score != '1) score <= score + SCORE_W'(1);
                state <= S_IDLE;
              end else begin
                miss   <= 1'b1;
                misses <= misses_inc;
                state  <= end_on_miss ? S_OVER : S_IDLE;
              end
            end else if (timer == '0) begin
              mole_up <= 1'b0;
              miss    <= 1'b1;
              misses  <= misses_inc;
              state   <= end_on_miss ? S_OVER : S_IDLE;
            end else begin
              timer <= timer - TIMER_W'(1);
            end
          end
          S_OVER: state <= S_OVER;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
